// File: rtl/mult_pkg.sv
// Shared types and default width for the shift-add multiplier.
package mult_pkg;
  localparam int MULT_N = 8;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, HOLD} state_t;
endpackage

// File: rtl/add_sub_n.sv
// Combinational (N+1)-bit adder/subtractor. Operands are sign- or zero-extended
// by one bit so the full sum or difference, carry included, fits in sum.
module add_sub_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         sgn,
  output logic [N:0]   sum
);
  logic [N:0] ext_a;
  logic [N:0] ext_b;

  assign ext_a = {sgn & a[N-1], a};
  assign ext_b = {sgn & b[N-1], b};
  assign sum   = sub ? (ext_a - ext_b) : (ext_a + ext_b);
endmodule

// File: rtl/shift_add_mult_n.sv
// Sequential N-bit shift-add multiplier: {X, A, B} = S * B, signed or unsigned.
// B doubles as the multiplier and the product low half, so results can be chained.
module shift_add_mult_n
  import mult_pkg::*;
#(
  parameter  int N     = MULT_N,
  localparam int CNT_W = $clog2(N)
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Load_Clear,
  input  logic         Run,
  input  logic         Signed_mode,
  input  logic [N-1:0] Din,
  output logic [N-1:0] Aval,
  output logic [N-1:0] Bval,
  output logic         Xval,
  output logic         Busy,
  output logic         Done
);
  state_t             state;
  logic [N-1:0]       a;
  logic [N-1:0]       b;
  logic [N-1:0]       s;
  logic               x;
  logic [CNT_W-1:0]   count;
  logic               mode;
  logic               busy;
  logic               done;
  logic               last_iter;
  logic [N:0]         sum;

  assign last_iter = (count == CNT_W'(N - 1));

  // The multiplier MSB carries negative weight in two's complement, so the
  // final partial product is subtracted rather than added.
  add_sub_n #(.N(N)) u_add_sub (
    .a   (a),
    .b   (s),
    .sub (mode & last_iter),
    .sgn (mode),
    .sum (sum)
  );

  // NOTE: reset is synchronous, so it lives inside the clocked branch; all
  // state is assigned with <= so every register sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      x     <= 1'b0;
      count <= '0;
      mode  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Load_Clear) begin
            x <= 1'b0;
            a <= '0;
            b <= Din;
          end else if (Run) begin
            s     <= Din;
            mode  <= Signed_mode;
            x     <= 1'b0;
            a     <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          if (b[0]) {x, a} <= sum;
          state <= SHIFT;
        end
        SHIFT: begin
          // Signed mode replicates X into A; unsigned mode drains the carry.
          a <= {x, a[N-1:1]};
          b <= {a[0], b[N-1:1]};
          if (!mode) x <= 1'b0;
          if (last_iter) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= HOLD;
          end else begin
            count <= count + CNT_W'(1);
            state <= ADD;
          end
        end
        HOLD: begin
          if (!Run) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Aval = a;
  assign Bval = b;
  assign Xval = x;
  assign Busy = busy;
  assign Done = done;
endmodule
